// File: rtl/aes_pkg.sv
// Shared AES-128 constants, FSM encodings and byte/word helpers for the decryption key scheduler.
package aes_pkg;

  localparam int unsigned NR    = 10;
  localparam int unsigned RK_W  = 128;
  localparam int unsigned IDX_W = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FWD  = 2'd1;
  localparam logic [1:0] ST_EMIT = 2'd2;

  // Forward S-box, entry 0x00 in the most significant byte
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] rcon(input logic [IDX_W-1:0] idx);
    case (idx)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TBL[{8'hff - b, 3'b000} +: 8];
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Products of one byte by {0e, 0b, 0d, 09}
  function automatic logic [31:0] inv_mul(input logic [7:0] b);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return {x8 ^ x4 ^ x2, x8 ^ x2 ^ b, x8 ^ x4 ^ b, x8 ^ b};
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [31:0] m0, m1, m2, m3;
    m0 = inv_mul(c[31:24]);
    m1 = inv_mul(c[23:16]);
    m2 = inv_mul(c[15:8]);
    m3 = inv_mul(c[7:0]);
    return {m0[31:24] ^ m1[23:16] ^ m2[15:8]  ^ m3[7:0],
            m0[7:0]   ^ m1[31:24] ^ m2[23:16] ^ m3[15:8],
            m0[15:8]  ^ m1[7:0]   ^ m2[31:24] ^ m3[23:16],
            m0[23:16] ^ m1[15:8]  ^ m2[7:0]   ^ m3[31:24]};
  endfunction

endpackage

// File: rtl/aes_key_step.sv
// One AES-128 key-schedule round step, forward or inverse, around a single shared SubWord.
module aes_key_step
  import aes_pkg::*;
(
  input  logic             dir_i,
  input  logic [IDX_W-1:0] rnd_i,
  input  logic [RK_W-1:0]  key_i,
  output logic [RK_W-1:0]  key_o
);

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] sw_in, sw_rot, sw_out, t0;

  assign {w0, w1, w2, w3} = key_i;

  // Inverse direction needs the previous key's w3, which is w3^w2 of the current key
  assign sw_in  = dir_i ? (w3 ^ w2) : w3;
  assign sw_rot = rot_word(sw_in);

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    assign sw_out[g*8 +: 8] = sbox(sw_rot[g*8 +: 8]);
  end

  assign t0 = w0 ^ sw_out ^ {rcon(rnd_i), 24'h0};

  assign key_o = dir_i ? {t0, w1 ^ w0, w2 ^ w1, w3 ^ w2}
                       : {t0, w1 ^ t0, w2 ^ w1 ^ t0, w3 ^ w2 ^ w1 ^ t0};

endmodule

// File: rtl/aes_inv_key_sched.sv
// AES-128 decryption key scheduler: forward-expands in place, then streams round keys 10..0.
// Optional AES_EQ_INV_KEY_EN emits InvMixColumns'd keys for rounds 1..9 (equivalent inverse cipher).
module aes_inv_key_sched #(
  parameter int unsigned NR   = aes_pkg::NR,
  parameter int unsigned RK_W = aes_pkg::RK_W
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [RK_W-1:0] keyIn,
  input  logic            keyValid,
  output logic            keyReady,
  output logic [RK_W-1:0] roundKey,
  output logic [3:0]      roundIdx,
  output logic            rkValid,
  input  logic            rkReady,
  output logic            busy
);

  if (NR != 10 || RK_W != 128) begin : g_bad_cfg
    $error("aes_inv_key_sched supports only AES-128 (NR=10, RK_W=128)");
  end

  logic [1:0]      state_q, state_d;
  logic [RK_W-1:0] key_q, key_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [3:0]      idx_q, idx_d;
  logic            rk_valid_q, rk_valid_d;
  logic            key_ready_q, key_ready_d;
  logic            busy_q, busy_d;
  logic            step_dir;
  logic [3:0]      step_rnd;
  logic [RK_W-1:0] step_key;

  assign step_dir = (state_q == aes_pkg::ST_EMIT);
  assign step_rnd = step_dir ? idx_q : cnt_q;

  aes_key_step u_step (
    .dir_i (step_dir),
    .rnd_i (step_rnd),
    .key_i (key_q),
    .key_o (step_key)
  );

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    case (state_q)
      aes_pkg::ST_IDLE: begin
        if (keyValid) begin
          key_d   = keyIn;
          cnt_d   = 4'd1;
          state_d = aes_pkg::ST_FWD;
        end
      end
      aes_pkg::ST_FWD: begin
        key_d = step_key;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'(NR)) begin
          cnt_d   = 4'd0;
          idx_d   = 4'(NR);
          state_d = aes_pkg::ST_EMIT;
        end
      end
      aes_pkg::ST_EMIT: begin
        if (rkReady) begin
          if (idx_q != 4'd0) begin
            key_d = step_key;
            idx_d = idx_q - 4'd1;
          end else begin
            state_d = aes_pkg::ST_IDLE;
          end
        end
      end
      default: state_d = aes_pkg::ST_IDLE;
    endcase
    rk_valid_d  = (state_d == aes_pkg::ST_EMIT);
    key_ready_d = (state_d == aes_pkg::ST_IDLE);
    busy_d      = (state_d != aes_pkg::ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= aes_pkg::ST_IDLE;
      key_q       <= '0;
      cnt_q       <= '0;
      idx_q       <= '0;
      rk_valid_q  <= 1'b0;
      key_ready_q <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      key_q       <= key_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      rk_valid_q  <= rk_valid_d;
      key_ready_q <= key_ready_d;
      busy_q      <= busy_d;
    end
  end

`ifdef AES_EQ_INV_KEY_EN
  logic [RK_W-1:0] rk_q, rk_d, imc_d;

  for (genvar c = 0; c < 4; c++) begin : g_imc
    assign imc_d[RK_W-1-32*c -: 32] = aes_pkg::inv_mix_col(key_d[RK_W-1-32*c -: 32]);
  end

  // Rounds 10 and 0 stay raw; intermediate rounds get InvMixColumns
  always_comb begin
    rk_d = key_d;
    if (idx_d != 4'd0 && idx_d != 4'(NR)) rk_d = imc_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rk_q <= '0;
    else        rk_q <= rk_d;
  end

  assign roundKey = rk_q;
`else
  assign roundKey = key_q;
`endif

  assign keyReady = key_ready_q;
  assign roundIdx = idx_q;
  assign rkValid  = rk_valid_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_aes_inv_key_sched.sv
// Randomized self-checking bench for aes_inv_key_sched against a GF(2^8)-derived key-expansion model.
module tb_aes_inv_key_sched;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] keyIn;
  logic         keyValid;
  logic         keyReady;
  logic [127:0] roundKey;
  logic [3:0]   roundIdx;
  logic         rkValid;
  logic         rkReady;
  logic         busy;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0]   sbox_m [256];
  logic [127:0] exp_rk [11];
  logic [127:0] got_rk [11];

  aes_inv_key_sched dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .keyIn    (keyIn),
    .keyValid (keyValid),
    .keyReady (keyReady),
    .roundKey (roundKey),
    .roundIdx (roundIdx),
    .rkValid  (rkValid),
    .rkReady  (rkReady),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box from first principles: multiplicative inverse (a^254) followed by the affine map
  task automatic build_sbox();
    logic [7:0] inv;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h01;
      for (int k = 0; k < 254; k++) inv = gf_mul(inv, 8'(a));
      sbox_m[a] = 8'h63 ^ inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                        ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]};
    end
  endtask

  function automatic logic [127:0] inv_mix(input logic [127:0] s);
    logic [7:0]   m [4];
    logic [7:0]   acc;
    logic [127:0] o;
    m = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++) acc = acc ^ gf_mul(m[(j - r + 4) % 4], s[127 - 32*c - 8*j -: 8]);
        o[127 - 32*c - 8*r -: 8] = acc;
      end
    return o;
  endfunction

  // Full forward expansion into 44 words, sliced into the 11 round keys
  task automatic model_expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_m[t[31:24]], sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]};
        t[31:24] = t[31:24] ^ rc;
        rc = gf_mul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++) begin
      exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
`ifdef AES_EQ_INV_KEY_EN
      if (r >= 1 && r <= 9) exp_rk[r] = inv_mix(exp_rk[r]);
`endif
    end
  endtask

  task automatic start_key(input logic [127:0] key);
    @(negedge clk);
    check("key_ready_idle", 128'(keyReady), 128'd1);
    keyIn    = key;
    keyValid = 1'b1;
    @(posedge clk);
    #1;
    keyValid = 1'b0;
  endtask

  // Called just after an accepting edge; consumes all 11 round keys with rkReady at the given duty (%)
  task automatic drain(input logic [127:0] key, input int duty);
    int   lat;
    int   stalls;
    logic rdy;
    model_expand(key);
    rkReady = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        check("busy_fwd", 128'(busy), 128'd1);
        check("key_ready_fwd", 128'(keyReady), 128'd0);
      end
    end while (!rkValid && lat < 40);
    check("first_rk_latency", 128'(lat), 128'd11);
    if (!rkValid) return;
    for (int k = 10; k >= 0; k--) begin
      rdy = 1'b0;
      stalls = 0;
      while (!rdy) begin
        check("rk_valid", 128'(rkValid), 128'd1);
        check("key_ready_emit", 128'(keyReady), 128'd0);
        check("round_idx", 128'(roundIdx), 128'(k));
        check("round_key", roundKey, exp_rk[k]);
        got_rk[k] = roundKey;
        rdy = ($urandom_range(0, 99) < duty) || (stalls >= 30);
        rkReady = rdy;
        stalls++;
        @(negedge clk);
      end
    end
    rkReady = 1'b0;
    check("rk_valid_done", 128'(rkValid), 128'd0);
    check("key_ready_done", 128'(keyReady), 128'd1);
    check("busy_done", 128'(busy), 128'd0);
  endtask

  task automatic reset_pulse(input string tag);
    rst_n = 1'b0;
    #1;
    check({tag, "_rst_key_ready"}, 128'(keyReady), 128'd1);
    check({tag, "_rst_rk_valid"}, 128'(rkValid), 128'd0);
    check({tag, "_rst_busy"}, 128'(busy), 128'd0);
    check({tag, "_rst_round_key"}, roundKey, 128'd0);
    check({tag, "_rst_round_idx"}, 128'(roundIdx), 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [127:0] k1, k2;
    int           n;
    rst_n    = 1'b0;
    keyIn    = '0;
    keyValid = 1'b0;
    rkReady  = 1'b0;
    build_sbox();
    @(negedge clk);
    check("reset_key_ready", 128'(keyReady), 128'd1);
    check("reset_rk_valid", 128'(rkValid), 128'd0);
    check("reset_busy", 128'(busy), 128'd0);
    check("reset_round_key", roundKey, 128'd0);
    check("reset_round_idx", 128'(roundIdx), 128'd0);
    rst_n = 1'b1;

    // Known-answer key, full throughput
    k1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    start_key(k1);
    drain(k1, 100);
    check("kat_r10", got_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    check("kat_r0", got_rk[0], k1);
`ifndef AES_EQ_INV_KEY_EN
    check("kat_r9", got_rk[9], 128'hac7766f319fadc2128d12941575c006e);
    check("kat_r1", got_rk[1], 128'ha0fafe1788542cb123a339392a6c7605);
`endif

    // Same key with a mostly-stalled consumer
    start_key(k1);
    drain(k1, 30);

    // keyValid held high with another key through the whole run
    k2 = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    keyIn    = k1;
    keyValid = 1'b1;
    @(posedge clk);
    #1;
    keyIn = k2;
    drain(k1, 100);
    @(posedge clk);
    #1;
    keyValid = 1'b0;
    drain(k2, 100);

    // Async reset mid-forward-expansion and mid-emission
    start_key({$urandom, $urandom, $urandom, $urandom});
    repeat (4) @(negedge clk);
    reset_pulse("fwd");
    start_key({$urandom, $urandom, $urandom, $urandom});
    rkReady = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(rkValid && roundIdx == 4'd6) && n < 60);
    check("reach_idx6", 128'(n), 128'd15);
    reset_pulse("emit");
    rkReady = 1'b0;
    k2 = {$urandom, $urandom, $urandom, $urandom};
    start_key(k2);
    drain(k2, 100);

    // Random keys, occasional back-pressure
    for (int i = 0; i < 1000; i++) begin
      k2 = {$urandom, $urandom, $urandom, $urandom};
      start_key(k2);
      drain(k2, (i % 4 == 0) ? 60 : 100);
    end

    // All-zero key
    start_key(128'd0);
    drain(128'd0, 100);
    check("zero_r10", got_rk[10], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
    check("zero_r0", got_rk[0], 128'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
